// File: rtl/xalu_md_ctrl_if.sv
// EX-stage multiply/divide bus: operation request, hazard feedback and HI/LO.
// Latency: none, this is wiring only.
// Backpressure: busy and stall flow back to the pipeline. There is no ready signal.
interface xalu_md_ctrl_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        flush;
  logic        md_use_d;
  logic        busy;
  logic        stall;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  // Pipeline side: issues operations and consumes status and results.
  modport master (
    output start, op, src_a, src_b, flush, md_use_d,
    input  busy, stall, done, hi, lo
  );

  // Sequencer side.
  modport slave (
    input  start, op, src_a, src_b, flush, md_use_d,
    output busy, stall, done, hi, lo
  );
endinterface

// File: rtl/xalu_md_ctrl.sv
// Multiply/divide sequencer. It holds HI/LO and times MULT/DIV latency for the hazard unit.
// Latency: MULT_CYCLES or DIV_CYCLES busy cycles after accept. MTHI/MTLO write at the accepting edge.
// Backpressure: busy plus a combinational stall. A start seen while running is ignored.
module xalu_md_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic           clk,
  input  logic           reset,
  xalu_md_ctrl_if.slave  md
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] MULT_LD = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_LD  = CW'(DIV_CYCLES);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    op_q, op_d;
  logic [31:0]   a_q, a_d, b_q, b_d;
  logic [31:0]   hi_q, hi_d, lo_q, lo_d;
  logic          busy_q, busy_d, done_q, done_d;

  logic        live, op_ok, op_md, acc;
  logic signed [63:0] prod_s;
  logic [63:0]        prod_u;
  logic signed [31:0] quot_s, rem_s;
  logic [31:0]        quot_u, rem_u;
  logic [31:0]        res_hi, res_lo;
  logic               res_we;

  assign live  = md.start & ~md.flush;
  assign op_ok = (md.op != 3'd0) && (md.op != 3'd7);
  assign op_md = (md.op >= 3'd1) && (md.op <= 3'd4);
  assign acc   = live & (state_q == IDLE) & op_ok;

  // Result datapath. It works only on the latched operands, so src changes during RUN are invisible.
  always_comb begin
    prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
    prod_u = {32'd0, a_q} * {32'd0, b_q};
    quot_s = '0;
    rem_s  = '0;
    quot_u = '0;
    rem_u  = '0;
    if (b_q != 32'd0) begin
      quot_u = a_q / b_q;
      rem_u  = a_q % b_q;
      // The most negative value divided by -1 overflows. Pin the result to the architectural answer.
      if (a_q == 32'h8000_0000 && b_q == 32'hFFFF_FFFF) begin
        quot_s = 32'sh8000_0000;
        rem_s  = '0;
      end else begin
        quot_s = $signed(a_q) / $signed(b_q);
        rem_s  = $signed(a_q) % $signed(b_q);
      end
    end
    res_hi = hi_q;
    res_lo = lo_q;
    res_we = 1'b0;
    case (op_q)
      3'd1: begin res_we = 1'b1; {res_hi, res_lo} = prod_s; end
      3'd2: begin res_we = 1'b1; {res_hi, res_lo} = prod_u; end
      3'd3: begin res_we = (b_q != 32'd0); res_hi = rem_s; res_lo = quot_s; end
      3'd4: begin res_we = (b_q != 32'd0); res_hi = rem_u; res_lo = quot_u; end
      default: ;
    endcase
  end

  // Next-state logic for the IDLE/RUN sequencer, the operand latches and HI/LO.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (acc) begin
          if (op_md) begin
            op_d    = md.op;
            a_d     = md.src_a;
            b_d     = md.src_b;
            cnt_d   = (md.op <= 3'd2) ? MULT_LD : DIV_LD;
            state_d = RUN;
            busy_d  = 1'b1;
          end else if (md.op == 3'd5) begin
            hi_d = md.src_a;
          end else begin
            lo_d = md.src_a;
          end
        end
      end
      RUN: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          if (res_we) begin
            hi_d = res_hi;
            lo_d = res_lo;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers. Reset aborts any in-flight operation without writing HI/LO.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= 3'd0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign md.stall = md.md_use_d & (busy_q | (live & op_md));
  assign md.busy  = busy_q;
  assign md.done  = done_q;
  assign md.hi    = hi_q;
  assign md.lo    = lo_q;

endmodule

// File: tb/tb_xalu_md_ctrl.sv
// Bench for the multiply/divide sequencer. Expected HI/LO are queued at issue and compared at done.
// Latency: checks busy length, done timing and stall cycle by cycle.
// Backpressure: exercises stall with md_use_d, flush gating and back-to-back issue.
module tb_xalu_md_ctrl;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  xalu_md_ctrl_if md_if ();

  xalu_md_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .md    (md_if)
  );

  int          total = 0;
  int          bad   = 0;
  logic [31:0] hi_m  = '0;
  logic [31:0] lo_m  = '0;
  exp_t        sb[$];

  task idle_inputs;
    md_if.start    = 1'b0;
    md_if.op       = 3'd0;
    md_if.src_a    = '0;
    md_if.src_b    = '0;
    md_if.flush    = 1'b0;
    md_if.md_use_d = 1'b0;
  endtask

  // Issue one mult/div op in the current cycle, then follow it to done.
  // The task returns at the negedge of the done cycle, so a following call issues back-to-back.
  task do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input int n,
             input logic use_d, input logic wiggle, input logic [31:0] eh, input logic [31:0] el);
    exp_t e;
    int   cnt;
    md_if.op       = op;
    md_if.src_a    = a;
    md_if.src_b    = b;
    md_if.md_use_d = use_d;
    md_if.flush    = 1'b0;
    md_if.start    = 1'b1;
    e.hi = eh;
    e.lo = el;
    sb.push_back(e);
    #1;
    total++;
    if (md_if.stall !== use_d) begin
      bad++;
      $display("FAIL start_stall op=%0d: got %b want %b", op, md_if.stall, use_d);
    end
    @(posedge clk);
    #1;
    md_if.start = 1'b0;
    md_if.op    = 3'd0;
    cnt = 0;
    for (int k = 0; k < n + 4; k++) begin
      @(negedge clk);
      if (md_if.busy !== 1'b1) break;
      cnt++;
      total++;
      if (md_if.stall !== use_d || md_if.hi !== hi_m || md_if.lo !== lo_m) begin
        bad++;
        $display("FAIL run_cycle op=%0d k=%0d: stall=%b hi=%h lo=%h want stall=%b hi=%h lo=%h",
                 op, k, md_if.stall, md_if.hi, md_if.lo, use_d, hi_m, lo_m);
      end
      if (wiggle) begin
        md_if.src_a = $urandom;
        md_if.src_b = $urandom;
        md_if.flush = 1'b1;
      end
    end
    md_if.flush = 1'b0;
    total++;
    if (cnt !== n) begin
      bad++;
      $display("FAIL busy_cycles op=%0d: got %0d want %0d", op, cnt, n);
    end
    total++;
    if (md_if.done !== 1'b1) begin
      bad++;
      $display("FAIL done_pulse op=%0d: got %b want 1", op, md_if.done);
    end
    total++;
    if (md_if.stall !== 1'b0) begin
      bad++;
      $display("FAIL stall_clear op=%0d: got %b want 0", op, md_if.stall);
    end
    e = sb.pop_front();
    total++;
    if (md_if.hi !== e.hi || md_if.lo !== e.lo) begin
      bad++;
      $display("FAIL result op=%0d: got hi=%h lo=%h want hi=%h lo=%h", op, md_if.hi, md_if.lo, e.hi, e.lo);
    end
    hi_m = e.hi;
    lo_m = e.lo;
    md_if.md_use_d = 1'b0;
  endtask

  task check_done_low(input string tag);
    @(negedge clk);
    total++;
    if (md_if.done !== 1'b0 || md_if.busy !== 1'b0) begin
      bad++;
      $display("FAIL %s_after: got done=%b busy=%b want 0 0", tag, md_if.done, md_if.busy);
    end
  endtask

  task test_reset;
    int dones;
    reset = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    total++;
    if (md_if.busy !== 1'b0 || md_if.done !== 1'b0 || md_if.hi !== 32'd0 || md_if.lo !== 32'd0 || md_if.stall !== 1'b0) begin
      bad++;
      $display("FAIL reset_values: busy=%b done=%b hi=%h lo=%h stall=%b want all 0",
               md_if.busy, md_if.done, md_if.hi, md_if.lo, md_if.stall);
    end
    reset = 1'b1;
    // Put a nonzero value in LO so that the reset clear is visible.
    md_if.op = 3'd6; md_if.src_a = 32'h55; md_if.start = 1'b1;
    @(posedge clk); #1;
    md_if.start = 1'b0;
    total++;
    if (md_if.lo !== 32'h55) begin
      bad++;
      $display("FAIL mtlo_pre_reset: got %h want 00000055", md_if.lo);
    end
    // Start a DIV 100/7, then kill it partway through.
    md_if.op = 3'd3; md_if.src_a = 32'd100; md_if.src_b = 32'd7; md_if.start = 1'b1;
    @(posedge clk); #1;
    md_if.start = 1'b0; md_if.op = 3'd0;
    repeat (3) @(negedge clk);
    total++;
    if (md_if.busy !== 1'b1) begin
      bad++;
      $display("FAIL div_busy_pre_reset: got %b want 1", md_if.busy);
    end
    #2 reset = 1'b0;
    #1;
    total++;
    if (md_if.busy !== 1'b0 || md_if.hi !== 32'd0 || md_if.lo !== 32'd0 || md_if.done !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: busy=%b done=%b hi=%h lo=%h want 0 0 0 0",
               md_if.busy, md_if.done, md_if.hi, md_if.lo);
    end
    @(negedge clk);
    reset = 1'b1;
    dones = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (md_if.done === 1'b1 || md_if.busy === 1'b1) dones++;
    end
    total++;
    if (dones != 0 || md_if.hi !== 32'd0 || md_if.lo !== 32'd0) begin
      bad++;
      $display("FAIL no_late_write: activity=%0d hi=%h lo=%h want 0 0 0", dones, md_if.hi, md_if.lo);
    end
    hi_m = '0;
    lo_m = '0;
  endtask

  task test_mult;
    do_op(3'd1, 32'hFFFF_FFFF, 32'd2, 5, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    check_done_low("mult");
    do_op(3'd2, 32'hFFFF_FFFF, 32'd2, 5, 1'b0, 1'b0, 32'h0000_0001, 32'hFFFF_FFFE);
    check_done_low("multu");
  endtask

  task test_div;
    do_op(3'd3, 32'hFFFF_FFF9, 32'd2, 10, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    check_done_low("div_neg");
    do_op(3'd4, 32'd7, 32'd2, 10, 1'b0, 1'b0, 32'd1, 32'd3);
    check_done_low("divu");
    do_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, 1'b0, 1'b0, 32'd0, 32'h8000_0000);
    check_done_low("div_ovf");
    // A divide by zero keeps the previous HI/LO.
    do_op(3'd3, 32'd5, 32'd0, 10, 1'b0, 1'b0, hi_m, lo_m);
    check_done_low("div_zero");
  endtask

  task test_stall;
    do_op(3'd1, 32'd3, 32'd4, 5, 1'b1, 1'b0, 32'd0, 32'd12);
    check_done_low("stall_mult");
    do_op(3'd4, 32'd100, 32'd7, 10, 1'b1, 1'b0, 32'd2, 32'd14);
    check_done_low("stall_divu");
  endtask

  task test_mt_flush;
    md_if.op = 3'd5; md_if.src_a = 32'h1234_5678; md_if.md_use_d = 1'b1; md_if.start = 1'b1;
    #1;
    total++;
    if (md_if.stall !== 1'b0) begin
      bad++;
      $display("FAIL mthi_stall: got %b want 0", md_if.stall);
    end
    @(posedge clk); #1;
    md_if.start = 1'b0; md_if.md_use_d = 1'b0;
    total++;
    if (md_if.hi !== 32'h1234_5678 || md_if.lo !== lo_m || md_if.busy !== 1'b0) begin
      bad++;
      $display("FAIL mthi: hi=%h lo=%h busy=%b want %h %h 0", md_if.hi, md_if.lo, md_if.busy, 32'h1234_5678, lo_m);
    end
    hi_m = 32'h1234_5678;
    check_done_low("mthi");
    md_if.op = 3'd6; md_if.src_a = 32'hCAFE_F00D; md_if.start = 1'b1;
    @(posedge clk); #1;
    md_if.start = 1'b0;
    total++;
    if (md_if.lo !== 32'hCAFE_F00D || md_if.hi !== hi_m || md_if.busy !== 1'b0) begin
      bad++;
      $display("FAIL mtlo: hi=%h lo=%h busy=%b want %h cafef00d 0", md_if.hi, md_if.lo, md_if.busy, hi_m);
    end
    lo_m = 32'hCAFE_F00D;
    check_done_low("mtlo");
    // A flushed MULT must behave as if it never existed.
    md_if.op = 3'd1; md_if.src_a = 32'd7; md_if.src_b = 32'd9;
    md_if.md_use_d = 1'b1; md_if.flush = 1'b1; md_if.start = 1'b1;
    #1;
    total++;
    if (md_if.stall !== 1'b0) begin
      bad++;
      $display("FAIL flush_stall: got %b want 0", md_if.stall);
    end
    @(posedge clk); #1;
    md_if.start = 1'b0; md_if.flush = 1'b0; md_if.md_use_d = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      total++;
      if (md_if.busy !== 1'b0 || md_if.done !== 1'b0 || md_if.hi !== hi_m || md_if.lo !== lo_m) begin
        bad++;
        $display("FAIL flush_noop k=%0d: busy=%b done=%b hi=%h lo=%h want 0 0 %h %h",
                 k, md_if.busy, md_if.done, md_if.hi, md_if.lo, hi_m, lo_m);
      end
    end
  endtask

  task test_back_to_back;
    // Both ops scramble src_a/src_b and toggle flush while running.
    do_op(3'd1, 32'd6, 32'd7, 5, 1'b0, 1'b1, 32'd0, 32'd42);
    do_op(3'd1, 32'hFFFF_FFFD, 32'd5, 5, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    check_done_low("b2b");
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_stall();
    test_mt_flush();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
